ucsbece154b_branch_predictor: RTL and testbench
===============================================

Name: ucsbece154b_branch_predictor

Overview:
Fetch-stage branch predictor for the 5-stage RV32I pipeline. It combines a direct-mapped branch target buffer (BTB) with a gshare pattern history table (PHT) of 2-bit counters. From PCF it produces a combinational taken prediction and target that steer next-PC selection; the datapath carries these down the pipeline. It is trained from Execute-stage resolution, and its BranchTakenF output is what the top-level bench scores for mispredictions.

Parameters:
NUM_BTB_ENTRIES, 32, BTB depth; power of 2; index width BI = log2(NUM_BTB_ENTRIES).
NUM_GHR_BITS, 5, global history length; PHT depth = 2^NUM_GHR_BITS.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-high; clears all predictor state.
PCF_i  input  32  fetch PC.
BranchTakenF_o  output  1  predict redirect for PCF_i.
BTBtargetF_o  output  32  predicted target for PCF_i.
PHTindexF_o  output  NUM_GHR_BITS  gshare index used for PCF_i; piped to E by datapath.
PCE_i  input  32  PC of the instruction in Execute.
PCTargetE_i  input  32  resolved target in Execute.
BranchE_i  input  1  Execute instruction is a conditional branch.
JumpE_i  input  1  Execute instruction is jal/jalr.
BranchTakenE_i  input  1  resolved branch outcome; ignored unless BranchE_i.
PHTindexE_i  input  NUM_GHR_BITS  PHTindexF_o value carried with the Execute instruction.

Behaviour:
- Address split: BTB index = PC[BI+1:2]; tag = PC[31:BI+2]. Entry = {valid, tag, target[31:0], is_jump, is_branch}.
- PHT index (F) = PCF_i[NUM_GHR_BITS+1:2] XOR GHR.
- Prediction is combinational, with zero added latency:
  - hit = valid & (tag == PCF tag).
  - BranchTakenF_o = hit & (is_jump | (is_branch & PHT[PHTindexF_o][1])).
  - BTBtargetF_o = entry target when hit, else 32'b0.
- Update happens at posedge, only when BranchE_i | JumpE_i.
  - The BTB entry at PCE index is overwritten with valid=1, tag, PCTargetE_i, is_jump=JumpE_i, is_branch=BranchE_i.
  - If both BranchE_i and JumpE_i are asserted, treat the instruction as a jump.
- PHT training, only when BranchE_i:
  - Counter PHT[PHTindexE_i] increments if BranchTakenE_i, else decrements.
  - Counters saturate at 2'b11 and 2'b00.
  - Encoding: 00 strongly not taken, 01 weakly not taken, 10 weakly taken, 11 strongly taken.
- GHR, only when BranchE_i: GHR <= {GHR[NUM_GHR_BITS-2:0], BranchTakenE_i}. Jumps never shift the GHR.
- Read/write same-cycle collision: F sees the pre-update contents (old BTB entry, old counter, old GHR). The new values are visible from the next cycle.
- Alias/replacement: a tag mismatch overwrites the entry unconditionally (no allocation filter).
- Reset, including mid-operation:
  - All valid bits cleared, all PHT counters set to 2'b01, GHR cleared.
  - Outputs immediately become BranchTakenF_o=0, BTBtargetF_o=0, PHTindexF_o=PCF_i[NUM_GHR_BITS+1:2].
  - Updates presented while reset is asserted are dropped.
- Stall/flush: the block has no stall input. The datapath guarantees that BranchE_i and JumpE_i are 0 for bubbles and flushed slots, so each resolved instruction trains exactly once.
- Widths: all PC arithmetic is external; the block never adds to a PC.

Decomposition:
- Shared package ucsbece154b_bp_pkg holds:
  - Counter encodings: SNT, WNT, WT, ST.
  - PHT reset value WNT.
  - Opcode constants for branch (1100011), jal (1101111) and jalr (1100111), used by the datapath to form BranchE_i/JumpE_i.
  - BTB entry field widths as functions of the parameters.
- One sub-module, ucsbece154b_pht: holds the GHR and the counter array, with the read index output, the train port and the async reset. The BTB array stays in the top of this block.

Test Plan:
1. Cold start: reset, PCF_i=0x0000_0010 → BranchTakenF_o=0, BTBtargetF_o=0, PHTindexF_o=5'd4.
2. Jump install: one cycle of JumpE_i=1, PCE_i=0x24, PCTargetE_i=0x80; then PCF_i=0x24 → BranchTakenF_o=1, BTBtargetF_o=0x80. PCF_i=0x0A4 (same index, different tag) → BranchTakenF_o=0.
3. Counter training:
   - Branch at PC 0x40 resolved taken twice with PHTindexE_i=5'd16, GHR manually tracked.
   - Counter goes 01→10→11, GHR becomes 5'b00011.
   - PCF_i=0x40 now indexes 16^3=5'd19, which still holds 01 → BranchTakenF_o=0. This checks gshare hashing.
4. Saturation: five not-taken updates on one index → counter 00. A following taken update → 01 (no wrap to 11).
5. Collision: in the same cycle, PCF_i=0x24 and a JumpE_i update to 0x24 with target 0x100 → F shows the old target 0x80 that cycle and 0x100 the next.
6. Reset mid-run: assert reset asynchronously between edges after scenarios 2–3 → outputs drop to 0 the same cycle; GHR=0; the prior BTB entry at 0x24 misses after release.

Source files
------------

// File: rtl/ucsbece154b_branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_bp_pkg
// Description : Shared definitions for the fetch-stage branch predictor:
//               2-bit counter encodings, the PHT reset value, RV32I control
//               opcodes used by the datapath to form branch/jump strobes,
//               and BTB field-width helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ucsbece154b_bp_pkg;

   // 2-bit saturating counter encodings
   localparam logic [1:0] SNT = 2'b00;   // strongly not taken
   localparam logic [1:0] WNT = 2'b01;   // weakly not taken
   localparam logic [1:0] WT  = 2'b10;   // weakly taken
   localparam logic [1:0] ST  = 2'b11;   // strongly taken

   localparam logic [1:0] PHT_RESET = WNT;

   // Opcodes the datapath decodes into BranchE_i / JumpE_i
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // BTB index width: PC[BI+1:2]
   function automatic int btb_idx_w(input int num_entries);
      return $clog2(num_entries);
   endfunction

   // BTB tag width: PC[31:BI+2]
   function automatic int btb_tag_w(input int num_entries);
      return 30 - $clog2(num_entries);
   endfunction

   // Full entry: valid + tag + 32-bit target + is_jump + is_branch
   function automatic int btb_entry_w(input int num_entries);
      return 1 + btb_tag_w(num_entries) + 32 + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ucsbece154b_branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_branch_predictor_if
// Description : Fetch-prediction and Execute-training bus between the
//               datapath (master) and the branch predictor (slave).
// Signals     : PCF_i, BranchTakenF_o, BTBtargetF_o, PHTindexF_o  (fetch)
//               PCE_i, PCTargetE_i, BranchE_i, JumpE_i, BranchTakenE_i,
//               PHTindexE_i                                       (train)
// Revision    : 1.0 - initial release
// ============================================================================
interface ucsbece154b_branch_predictor_if #(
   parameter int NUM_GHR_BITS = 5
);
   logic [31:0]             PCF_i;
   logic                    BranchTakenF_o;
   logic [31:0]             BTBtargetF_o;
   logic [NUM_GHR_BITS-1:0] PHTindexF_o;
   logic [31:0]             PCE_i;
   logic [31:0]             PCTargetE_i;
   logic                    BranchE_i;
   logic                    JumpE_i;
   logic                    BranchTakenE_i;
   logic [NUM_GHR_BITS-1:0] PHTindexE_i;

   modport master (
      output PCF_i, PCE_i, PCTargetE_i, BranchE_i, JumpE_i,
             BranchTakenE_i, PHTindexE_i,
      input  BranchTakenF_o, BTBtargetF_o, PHTindexF_o
   );

   modport slave (
      input  PCF_i, PCE_i, PCTargetE_i, BranchE_i, JumpE_i,
             BranchTakenE_i, PHTindexE_i,
      output BranchTakenF_o, BTBtargetF_o, PHTindexF_o
   );
endinterface
`default_nettype wire

// File: rtl/ucsbece154b_branch_predictor_pht.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_pht
// Description : gshare pattern history table. Holds the global history
//               register and 2^NUM_GHR_BITS saturating 2-bit counters.
// Ports       : clk, reset      - clock, async active-high reset
//               pc_bits         - PCF[NUM_GHR_BITS+1:2]
//               rd_idx          - gshare index for the fetch PC
//               rd_taken        - MSB of the counter at rd_idx
//               train_en        - a conditional branch resolved in Execute
//               train_idx       - index carried down with that branch
//               train_taken     - its resolved outcome
// Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154b_pht
   import ucsbece154b_bp_pkg::*;
#(
   parameter int NUM_GHR_BITS = 5
) (
   input  wire logic                    clk,
   input  wire logic                    reset,
   input  wire logic [NUM_GHR_BITS-1:0] pc_bits,
   output logic      [NUM_GHR_BITS-1:0] rd_idx,
   output logic                         rd_taken,
   input  wire logic                    train_en,
   input  wire logic [NUM_GHR_BITS-1:0] train_idx,
   input  wire logic                    train_taken
);
   localparam int DEPTH = 1 << NUM_GHR_BITS;

   logic [NUM_GHR_BITS-1:0] r_ghr;
   logic [1:0]              r_ctr [DEPTH];

   // Reads see pre-update state, so a same-cycle train is invisible here.
   assign rd_idx   = pc_bits ^ r_ghr;
   assign rd_taken = r_ctr[rd_idx][1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ghr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_ctr[i] <= PHT_RESET;
         end
      end else if (train_en) begin
         r_ghr <= {r_ghr[NUM_GHR_BITS-2:0], train_taken};
         if (train_taken && (r_ctr[train_idx] != ST)) begin
            r_ctr[train_idx] <= r_ctr[train_idx] + 2'd1;
         end else if (!train_taken && (r_ctr[train_idx] != SNT)) begin
            r_ctr[train_idx] <= r_ctr[train_idx] - 2'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ucsbece154b_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_branch_predictor
// Description : Fetch-stage predictor: direct-mapped BTB plus gshare PHT.
//               Prediction is combinational from PCF; training happens on
//               the clock edge from Execute-stage resolution.
// Ports       : clk    - clock
//               reset  - async active-high, clears all predictor state
//               bp     - predictor bus (slave side), see the interface
// Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154b_branch_predictor
   import ucsbece154b_bp_pkg::*;
#(
   parameter int NUM_BTB_ENTRIES = 32,
   parameter int NUM_GHR_BITS    = 5
) (
   input wire logic                     clk,
   input wire logic                     reset,
   ucsbece154b_branch_predictor_if.slave bp
);
   localparam int BI    = btb_idx_w(NUM_BTB_ENTRIES);
   localparam int TAG_W = btb_tag_w(NUM_BTB_ENTRIES);

   logic [NUM_BTB_ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]           r_tag       [NUM_BTB_ENTRIES];
   logic [31:0]                r_target    [NUM_BTB_ENTRIES];
   logic                       r_is_jump   [NUM_BTB_ENTRIES];
   logic                       r_is_branch [NUM_BTB_ENTRIES];

   logic [BI-1:0]    w_f_idx;
   logic [TAG_W-1:0] w_f_tag;
   logic [BI-1:0]    w_e_idx;
   logic [TAG_W-1:0] w_e_tag;
   logic             w_hit;
   logic             w_pht_taken;
   logic             w_upd;

   assign w_f_idx = bp.PCF_i[BI+1:2];
   assign w_f_tag = bp.PCF_i[31:BI+2];
   assign w_e_idx = bp.PCE_i[BI+1:2];
   assign w_e_tag = bp.PCE_i[31:BI+2];
   assign w_upd   = bp.BranchE_i | bp.JumpE_i;

   ucsbece154b_pht #(
      .NUM_GHR_BITS (NUM_GHR_BITS)
   ) u_pht (
      .clk         (clk),
      .reset       (reset),
      .pc_bits     (bp.PCF_i[NUM_GHR_BITS+1:2]),
      .rd_idx      (bp.PHTindexF_o),
      .rd_taken    (w_pht_taken),
      .train_en    (bp.BranchE_i),
      .train_idx   (bp.PHTindexE_i),
      .train_taken (bp.BranchTakenE_i)
   );

   assign w_hit             = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
   assign bp.BranchTakenF_o = w_hit &&
                              (r_is_jump[w_f_idx] || (r_is_branch[w_f_idx] && w_pht_taken));
   assign bp.BTBtargetF_o   = w_hit ? r_target[w_f_idx] : 32'b0;

   // Only the valid bits need reset; payload is don't-care while invalid.
   // A tag mismatch simply overwrites the slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
      end else if (w_upd) begin
         r_valid[w_e_idx]     <= 1'b1;
         r_tag[w_e_idx]       <= w_e_tag;
         r_target[w_e_idx]    <= bp.PCTargetE_i;
         r_is_jump[w_e_idx]   <= bp.JumpE_i;
         // A simultaneous branch+jump strobe is stored as a jump.
         r_is_branch[w_e_idx] <= bp.BranchE_i & ~bp.JumpE_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucsbece154b_branch_predictor
// Description : Self-checking bench for the BTB + gshare branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ucsbece154b_branch_predictor;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   ucsbece154b_branch_predictor_if #(.NUM_GHR_BITS(5)) bp ();

   ucsbece154b_branch_predictor #(
      .NUM_BTB_ENTRIES (32),
      .NUM_GHR_BITS    (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bp    (bp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pcf;
      logic [31:0] pce;
      logic [31:0] tgt;
      logic        br;
      logic        jmp;
      logic        tk;
      logic [4:0]  idxe;
      logic        exp_tk;
      logic [31:0] exp_tgt;
      logic [4:0]  exp_idx;
      logic        chk_idx;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] pcf, input logic [31:0] pce,
                               input logic [31:0] tgt, input logic br, input logic jmp,
                               input logic tk, input logic [4:0] idxe,
                               input logic exp_tk, input logic [31:0] exp_tgt,
                               input logic [4:0] exp_idx, input logic chk_idx);
      vec_t v;
      v.pcf = pcf; v.pce = pce; v.tgt = tgt; v.br = br; v.jmp = jmp; v.tk = tk;
      v.idxe = idxe; v.exp_tk = exp_tk; v.exp_tgt = exp_tgt; v.exp_idx = exp_idx;
      v.chk_idx = chk_idx;
      return v;
   endfunction

   task automatic drive(input logic [31:0] pcf, input logic [31:0] pce,
                        input logic [31:0] tgt, input logic br, input logic jmp,
                        input logic tk, input logic [4:0] idxe);
      bp.PCF_i          = pcf;
      bp.PCE_i          = pce;
      bp.PCTargetE_i    = tgt;
      bp.BranchE_i      = br;
      bp.JumpE_i        = jmp;
      bp.BranchTakenE_i = tk;
      bp.PHTindexE_i    = idxe;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Expected values follow a hand-tracked GHR and counter state.
      vecs[0]  = mk(32'h10, 32'h00, 32'h000, 0, 0, 0, 5'd0,  0, 32'h000, 5'd4,  1); // cold
      vecs[1]  = mk(32'h10, 32'h24, 32'h080, 0, 1, 0, 5'd0,  0, 32'h000, 5'd4,  1); // jump install
      vecs[2]  = mk(32'h24, 32'h00, 32'h000, 0, 0, 0, 5'd0,  1, 32'h080, 5'd9,  1);
      vecs[3]  = mk(32'hA4, 32'h00, 32'h000, 0, 0, 0, 5'd0,  0, 32'h000, 5'd9,  1); // tag miss
      vecs[4]  = mk(32'h40, 32'h40, 32'h060, 1, 0, 1, 5'd16, 0, 32'h000, 5'd16, 1); // ctr16 01->10
      vecs[5]  = mk(32'h40, 32'h40, 32'h060, 1, 0, 1, 5'd16, 0, 32'h060, 5'd17, 1); // ctr16 10->11
      vecs[6]  = mk(32'h40, 32'h00, 32'h000, 0, 0, 0, 5'd0,  0, 32'h060, 5'd19, 1); // gshare 16^3
      vecs[7]  = mk(32'h24, 32'h24, 32'h100, 0, 1, 0, 5'd0,  1, 32'h080, 5'd10, 1); // collision
      vecs[8]  = mk(32'h24, 32'h00, 32'h000, 0, 0, 0, 5'd0,  1, 32'h100, 5'd10, 1); // jump kept GHR
      vecs[9]  = mk(32'h44, 32'h44, 32'h070, 1, 0, 0, 5'd16, 0, 32'h000, 5'd18, 1); // 11->10
      vecs[10] = mk(32'h44, 32'h44, 32'h070, 1, 0, 0, 5'd16, 0, 32'h070, 5'd23, 1); // 10->01
      vecs[11] = mk(32'h44, 32'h44, 32'h070, 1, 0, 0, 5'd16, 0, 32'h070, 5'd29, 1); // 01->00
      vecs[12] = mk(32'h44, 32'h44, 32'h070, 1, 0, 0, 5'd16, 0, 32'h070, 5'd9,  1); // stays 00
      vecs[13] = mk(32'h44, 32'h44, 32'h070, 1, 0, 0, 5'd16, 0, 32'h070, 5'd1,  1); // stays 00
      vecs[14] = mk(32'h40, 32'h44, 32'h070, 1, 0, 1, 5'd16, 0, 32'h060, 5'd16, 1); // reads 00; ->01
      vecs[15] = mk(32'h44, 32'h4C, 32'h090, 1, 0, 1, 5'd16, 0, 32'h070, 5'd16, 1); // reads 01; ->10
      vecs[16] = mk(32'h4C, 32'h00, 32'h000, 0, 0, 0, 5'd0,  1, 32'h090, 5'd16, 1); // reads 10
      vecs[17] = mk(32'h4C, 32'h4C, 32'h0A0, 1, 1, 0, 5'd16, 1, 32'h090, 5'd16, 1); // br+jmp
      vecs[18] = mk(32'h4C, 32'h00, 32'h000, 0, 0, 0, 5'd0,  1, 32'h0A0, 5'd0,  0); // stored as jump

      drive(32'h10, 32'h0, 32'h0, 0, 0, 0, 5'd0);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("reset_taken", {31'b0, bp.BranchTakenF_o}, 32'h0);
      chk("reset_target", bp.BTBtargetF_o, 32'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].pcf, vecs[i].pce, vecs[i].tgt, vecs[i].br, vecs[i].jmp,
               vecs[i].tk, vecs[i].idxe);
         #1;
         chk($sformatf("v%0d_taken", i), {31'b0, bp.BranchTakenF_o}, {31'b0, vecs[i].exp_tk});
         chk($sformatf("v%0d_target", i), bp.BTBtargetF_o, vecs[i].exp_tgt);
         if (vecs[i].chk_idx)
            chk($sformatf("v%0d_index", i), {27'b0, bp.PHTindexF_o}, {27'b0, vecs[i].exp_idx});
         @(posedge clk);
         #1;
      end

      // Mid-run asynchronous reset with an update presented during reset.
      drive(32'h24, 32'h0, 32'h0, 0, 0, 0, 5'd0);
      #1;
      chk("pre_rst_taken", {31'b0, bp.BranchTakenF_o}, 32'h1);
      chk("pre_rst_target", bp.BTBtargetF_o, 32'h100);
      #2;
      reset = 1'b1;
      drive(32'h24, 32'h24, 32'h200, 1, 1, 1, 5'd0);
      #1;
      chk("rst_taken", {31'b0, bp.BranchTakenF_o}, 32'h0);
      chk("rst_target", bp.BTBtargetF_o, 32'h0);
      chk("rst_index", {27'b0, bp.PHTindexF_o}, 32'd9);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(32'h24, 32'h0, 32'h0, 0, 0, 0, 5'd0);
      #1;
      chk("post_rst_taken", {31'b0, bp.BranchTakenF_o}, 32'h0);
      chk("post_rst_target", bp.BTBtargetF_o, 32'h0);
      chk("post_rst_index", {27'b0, bp.PHTindexF_o}, 32'd9);
      drive(32'h40, 32'h0, 32'h0, 0, 0, 0, 5'd0);
      #1;
      chk("post_rst_b16_target", bp.BTBtargetF_o, 32'h0);
      chk("post_rst_b16_index", {27'b0, bp.PHTindexF_o}, 32'd16);

      // Normal training resumes after release.
      drive(32'h24, 32'h24, 32'h80, 1, 0, 1, 5'd0);
      @(posedge clk);
      #1;
      drive(32'h24, 32'h0, 32'h0, 0, 0, 0, 5'd0);
      #1;
      chk("reinstall_target", bp.BTBtargetF_o, 32'h80);
      chk("reinstall_index", {27'b0, bp.PHTindexF_o}, 32'd8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
